piso_tx: RTL



---
 rtl/piso_tx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - UART serial transmitter (parallel in, serial out) with parity
//
// Purpose:
//   Accepts a byte over a load/ready handshake, builds an 11-bit frame
//   {stop, parity, data[7:0], start} and shifts it out LSB-first on data_tx,
//   one bit per baud_clk edge, followed by STOP_BITS stop cycles.
//
// Parameters:
//   PARITY_ODD : 0 = even parity (parity = ^data), 1 = odd parity (parity = ~^data)
//   STOP_BITS  : number of stop-bit cycles, 1 or 2
//
// Optional feature:
//   PISO_TX_HOLD_EN : adds a one-entry hold register so a byte can be
//                     accepted while busy and sent with zero idle gap.
//
// Ports:
//   baud_clk    in   bit clock, one serial bit per rising edge
//   reset       in   asynchronous, active-high reset
//   data_in     in   byte to transmit, sampled when load && ready
//   load        in   transmit request (valid)
//   ready       out  block can accept a byte this cycle (combinational)
//   data_tx     out  serial line, idles high
//   tx_frame    out  registered copy of the frame being sent
//   active_flag out  high for every cycle data_tx carries a frame bit
//   done_flag   out  one-cycle pulse when a frame completes

module piso_tx #(
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic        baud_clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        load,
  output logic        ready,
  output logic        data_tx,
  output logic [10:0] tx_frame,
  output logic        active_flag,
  output logic        done_flag
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Stop counter value that marks the final stop cycle.
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        data_tx_q, data_tx_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
  logic [10:0] frame_q, frame_d;
  logic [7:0]  cur_data;

`ifdef PISO_TX_HOLD_EN
  logic        hold_valid_q, hold_valid_d;
  logic [7:0]  hold_data_q, hold_data_d;
`endif

  function automatic logic [10:0] build_frame(input logic [7:0] b);
    logic par;
    par = PARITY_ODD ? ~^b : ^b;
    return {1'b1, par, b, 1'b0};
  endfunction

`ifdef PISO_TX_HOLD_EN
  assign ready = (state_q == IDLE) | ~hold_valid_q;
`else
  assign ready = (state_q == IDLE);
`endif

  assign cur_data = frame_q[8:1];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    data_tx_d  = data_tx_q;
    active_d   = active_q;
    done_d     = 1'b0;
    frame_d    = frame_q;
`ifdef PISO_TX_HOLD_EN
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    // A byte accepted while a frame is in flight parks in the hold register.
    if (load && ready && (state_q != IDLE)) begin
      hold_valid_d = 1'b1;
      hold_data_d  = data_in;
    end
`endif

    case (state_q)
      IDLE: begin
        data_tx_d = 1'b1;
        if (load) begin
          frame_d   = build_frame(data_in);
          data_tx_d = 1'b0;
          active_d  = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        data_tx_d = cur_data[0];
        bit_cnt_d = 3'd0;
        state_d   = DATA;
      end
      DATA: begin
        if (bit_cnt_q == 3'd7) begin
          data_tx_d = frame_q[9];
          state_d   = PARITY;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          data_tx_d = cur_data[bit_cnt_q + 3'd1];
        end
      end
      PARITY: begin
        data_tx_d  = 1'b1;
        stop_cnt_d = 1'b0;
        state_d    = STOP;
      end
      STOP: begin
        data_tx_d = 1'b1;
        if (stop_cnt_q == STOP_LAST) begin
          done_d   = 1'b1;
          active_d = 1'b0;
          state_d  = IDLE;
`ifdef PISO_TX_HOLD_EN
          // Chain straight into the next frame: pending hold byte first,
          // otherwise a load arriving on this very edge.
          if (hold_valid_q || load) begin
            frame_d      = build_frame(hold_valid_q ? hold_data_q : data_in);
            data_tx_d    = 1'b0;
            active_d     = 1'b1;
            state_d      = START;
            hold_valid_d = 1'b0;
          end
`endif
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: begin
        data_tx_d = 1'b1;
        active_d  = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge baud_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      data_tx_q  <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      frame_q    <= 11'd0;
`ifdef PISO_TX_HOLD_EN
      hold_valid_q <= 1'b0;
      hold_data_q  <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      data_tx_q  <= data_tx_d;
      active_q   <= active_d;
      done_q     <= done_d;
      frame_q    <= frame_d;
`ifdef PISO_TX_HOLD_EN
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
`endif
    end
  end

  assign data_tx     = data_tx_q;
  assign tx_frame    = frame_q;
  assign active_flag = active_q;
  assign done_flag   = done_q;

endmodule
